// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS PIO bank: bus width, register word indices and
// the debounce counter sizing helper.
package hps_pio_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_OUT_SET  = 3'd2;
    localparam logic [2:0] REG_OUT_CLR  = 3'd3;
    localparam logic [2:0] REG_IRQ_MASK = 3'd4;
    localparam logic [2:0] REG_EDGE_CAP = 3'd5;
    localparam logic [2:0] REG_EDGE_SEL = 3'd6;
    localparam logic [2:0] REG_INFO     = 3'd7;

    // Wide enough to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One-bit input conditioner: 2-flop synchroniser, stability counter and
// debounced state, with combinational rise/fall pulses for the accepting cycle.
module pio_debounce
    import hps_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= RST_VAL;
            sync_q   <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            meta_q   <= din_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses lead stable_q by one cycle so capture lands on the same edge.
    assign stable_o = stable_q;
    assign rise_o   = accept & sync_q;
    assign fall_o   = accept & ~sync_q;

endmodule

// File: rtl/hps_pio_bank.sv
// Avalon-MM PIO bank: debounced input bank with polarity-selectable edge
// capture and maskable irq, plus an output register with atomic set/clear.
module hps_pio_bank
    import hps_pio_pkg::*;
#(
    parameter int unsigned IN_W            = 10,
    parameter int unsigned OUT_W           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] IN_RST_VAL      = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [BUS_W-1:0]  avs_writedata,
    output logic [BUS_W-1:0]  avs_readdata,
    input  logic [IN_W-1:0]   pio_in_export,
    output logic [OUT_W-1:0]  pio_out_export,
    output logic              irq
);

    logic [IN_W-1:0]  stable, rise, fall;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  cap_q, cap_d;
    logic [IN_W-1:0]  sel_q, sel_d;
    logic             irq_q, irq_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic [IN_W-1:0]  wdata_in;
    logic [OUT_W-1:0] wdata_out;
    logic             unused_wdata;

    for (genvar g = 0; g < IN_W; g++) begin : g_deb
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (IN_RST_VAL[g])
        ) u_deb (
            .clk_i    (clk_clk),
            .rst_ni   (reset_reset_n),
            .din_i    (pio_in_export[g]),
            .stable_o (stable[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g])
        );
    end

    assign wdata_in     = avs_writedata[IN_W-1:0];
    assign wdata_out    = avs_writedata[OUT_W-1:0];
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        dout_d = dout_q;
        mask_d = mask_q;
        sel_d  = sel_q;
        cap_d  = cap_q;
        if (avs_write) begin
            case (avs_address)
                REG_DATA_OUT: dout_d = wdata_out;
                REG_OUT_SET:  dout_d = dout_q | wdata_out;
                REG_OUT_CLR:  dout_d = dout_q & ~wdata_out;
                REG_IRQ_MASK: mask_d = wdata_in;
                REG_EDGE_CAP: cap_d  = cap_q & ~wdata_in;
                REG_EDGE_SEL: sel_d  = wdata_in;
                default: ;
            endcase
        end
        // New edges applied after the W1C so a colliding set wins.
        cap_d = cap_d | (rise & sel_q) | (fall & ~sel_q);
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                REG_DATA_IN:  rdata_d[IN_W-1:0]  = stable;
                REG_DATA_OUT: rdata_d[OUT_W-1:0] = dout_q;
                REG_IRQ_MASK: rdata_d[IN_W-1:0]  = mask_q;
                REG_EDGE_CAP: rdata_d[IN_W-1:0]  = cap_q;
                REG_EDGE_SEL: rdata_d[IN_W-1:0]  = sel_q;
                REG_INFO:     rdata_d = {8'd0, 8'(OUT_W), 8'd0, 8'(IN_W)};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            dout_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            sel_q   <= '1;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            dout_q  <= dout_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            sel_q   <= sel_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata   = rdata_q;
    assign pio_out_export = dout_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_hps_pio_bank.sv
// Directed bench for hps_pio_bank with a short debounce window.
module tb_hps_pio_bank;
    import hps_pio_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [9:0]  pio_in_export;
    logic [9:0]  pio_out_export;
    logic        irq;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [9:0]  exp_out;
    } vec_t;

    vec_t vecs[16];

    hps_pio_bank #(
        .IN_W            (10),
        .OUT_W           (10),
        .DEBOUNCE_CYCLES (4),
        .IN_RST_VAL      (32'h0)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .pio_in_export  (pio_in_export),
        .pio_out_export (pio_out_export),
        .irq            (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, REG_DATA_OUT, 32'h0000_00F0, 32'h0, 10'h0F0};
        vecs[1]  = '{1'b1, REG_OUT_SET,  32'h0000_0003, 32'h0, 10'h0F3};
        vecs[2]  = '{1'b0, REG_OUT_SET,  32'h0,         32'h0, 10'h0F3};
        vecs[3]  = '{1'b1, REG_OUT_CLR,  32'h0000_0030, 32'h0, 10'h0C3};
        vecs[4]  = '{1'b0, REG_OUT_CLR,  32'h0,         32'h0, 10'h0C3};
        vecs[5]  = '{1'b0, REG_DATA_OUT, 32'h0,         32'h0000_00C3, 10'h0C3};
        vecs[6]  = '{1'b1, REG_DATA_OUT, 32'hFFFF_FFFF, 32'h0, 10'h3FF};
        vecs[7]  = '{1'b0, REG_DATA_OUT, 32'h0,         32'h0000_03FF, 10'h3FF};
        vecs[8]  = '{1'b1, REG_IRQ_MASK, 32'h0000_0FFF, 32'h0, 10'h3FF};
        vecs[9]  = '{1'b0, REG_IRQ_MASK, 32'h0,         32'h0000_03FF, 10'h3FF};
        vecs[10] = '{1'b1, REG_IRQ_MASK, 32'h0,         32'h0, 10'h3FF};
        vecs[11] = '{1'b0, REG_EDGE_SEL, 32'h0,         32'h0000_03FF, 10'h3FF};
        vecs[12] = '{1'b0, REG_INFO,     32'h0,         32'h000A_000A, 10'h3FF};
        vecs[13] = '{1'b1, REG_DATA_IN,  32'h0000_03FF, 32'h0, 10'h3FF};
        vecs[14] = '{1'b0, REG_DATA_IN,  32'h0,         32'h0, 10'h3FF};
        vecs[15] = '{1'b1, REG_DATA_OUT, 32'h0,         32'h0, 10'h000};

        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        pio_in_export = '0;
        tick(3);
        reset_reset_n = 1'b1;
        tick(2);

        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_pio_out", {22'h0, pio_out_export}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_out", i), {22'h0, pio_out_export}, {22'h0, vecs[i].exp_out});
        end

        // Clean step on bit0: stable updates on the 6th edge after the change.
        pio_in_export[0] = 1'b1;
        tick(5);
        bus_read(REG_DATA_IN, rd);
        check("deb_edge6_pre", rd, 32'h0);
        bus_read(REG_DATA_IN, rd);
        check("deb_edge6_post", rd, 32'h1);
        bus_read(REG_EDGE_CAP, rd);
        check("cap_rise_bit0", rd, 32'h1);
        bus_write(REG_EDGE_CAP, 32'h1);

        // 3-cycle glitch on bit1 is rejected.
        pio_in_export[1] = 1'b1;
        tick(3);
        pio_in_export[1] = 1'b0;
        tick(10);
        bus_read(REG_DATA_IN, rd);
        check("glitch_data_in", rd, 32'h1);
        bus_read(REG_EDGE_CAP, rd);
        check("glitch_edge_cap", rd, 32'h0);

        // Falling capture on bit0 with irq one cycle after EDGE_CAP.
        bus_write(REG_IRQ_MASK, 32'h1);
        bus_write(REG_EDGE_SEL, 32'h0);
        pio_in_export[0] = 1'b0;
        tick(6);
        check("irq_lag", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_read(REG_EDGE_CAP, rd);
        check("cap_fall_bit0", rd, 32'h1);
        bus_write(REG_EDGE_CAP, 32'h1);
        tick(1);
        check("irq_clr", {31'h0, irq}, 32'h0);
        pio_in_export[0] = 1'b1;
        tick(10);
        bus_read(REG_EDGE_CAP, rd);
        check("cap_rise_ignored", rd, 32'h0);
        check("irq_after_rise", {31'h0, irq}, 32'h0);

        // W1C colliding with a new edge on bit2: the set wins.
        bus_write(REG_EDGE_SEL, 32'h3FF);
        pio_in_export[2] = 1'b1;
        tick(5);
        bus_write(REG_EDGE_CAP, 32'h4);
        bus_read(REG_EDGE_CAP, rd);
        check("w1c_collision", rd, 32'h4);
        bus_write(REG_EDGE_CAP, 32'h4);
        bus_read(REG_EDGE_CAP, rd);
        check("w1c_plain", rd, 32'h0);

        // Asynchronous reset mid-debounce.
        bus_write(REG_DATA_OUT, 32'h3FF);
        bus_write(REG_IRQ_MASK, 32'h3FF);
        bus_read(REG_DATA_OUT, rd);
        check("pre_rst_out", {22'h0, pio_out_export}, 32'h3FF);
        pio_in_export[3] = 1'b1;
        tick(2);
        #3;
        reset_reset_n = 1'b0;
        #1;
        check("arst_pio_out", {22'h0, pio_out_export}, 32'h0);
        check("arst_readdata", avs_readdata, 32'h0);
        check("arst_irq", {31'h0, irq}, 32'h0);
        pio_in_export = '0;
        #20;
        reset_reset_n = 1'b1;
        tick(12);
        bus_read(REG_EDGE_CAP, rd);
        check("post_rst_cap", rd, 32'h0);
        bus_read(REG_DATA_IN, rd);
        check("post_rst_data_in", rd, 32'h0);
        bus_read(REG_IRQ_MASK, rd);
        check("post_rst_mask", rd, 32'h0);
        bus_read(REG_EDGE_SEL, rd);
        check("post_rst_sel", rd, 32'h3FF);
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hps_pio_bank.md
Name: hps_pio_bank

Overview:
- Parametrised successor to the fixed-width PIO exports (key/sw/ledr/hex) on the HPS lightweight bridge.
- One Avalon-MM slave serves a configurable-width input bank and a configurable-width output bank.
- Inputs get per-bit synchronisation, debouncing, edge capture with selectable polarity, and a maskable interrupt.
- Outputs support atomic set and clear writes. Replaces separate key/sw/ledr PIO instances with one reusable block.

Parameters:
IN_W, 10, input bank width (1..32)
OUT_W, 10, output bank width (1..32)
DEBOUNCE_CYCLES, 50000, stable cycles needed before an input change is accepted (>=1; 1 = sync only)
IN_RST_VAL, 0, reset value of debounced input state (set to all-ones for active-low keys)

Ports:
clk_clk  in  1  single system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word register index
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, valid one cycle after avs_read
pio_in_export  in  IN_W  raw asynchronous inputs
pio_out_export  out  OUT_W  output register
irq  out  1  level interrupt, active-high

Behaviour:
- Reset values: readdata=0, pio_out_export=0, IRQ_MASK=0, EDGE_CAP=0, EDGE_SEL=all-ones (rising), debounced state=IN_RST_VAL, debounce counters=0, irq=0.
- Input path, per bit:
  - 2-flop synchroniser into sync.
  - If sync equals stable: counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes sync and the counter clears.
  - Latency from a clean input step to the stable change: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- Edge capture: when a stable bit changes in the selected direction (EDGE_SEL bit 1 = 0->1, 0 = 1->0), the matching EDGE_CAP bit sets in the same cycle the stable bit updates.
- irq = OR(EDGE_CAP & IRQ_MASK). It is registered, so it asserts one cycle after EDGE_CAP or IRQ_MASK changes.
- Register map (word index; read access; write effect):
  - 0 DATA_IN: RO, debounced state, zero-extended. Writes ignored.
  - 1 DATA_OUT: RW, full replace.
  - 2 OUT_SET: reads 0. Write ORs data into DATA_OUT.
  - 3 OUT_CLR: reads 0. Write clears DATA_OUT bits where data=1.
  - 4 IRQ_MASK: RW.
  - 5 EDGE_CAP: RW1C.
  - 6 EDGE_SEL: RW.
  - 7 INFO: RO, {8'd0, OUT_W[7:0], 8'd0, IN_W[7:0]}.
- Bits above IN_W/OUT_W read 0 and ignore writes.
- Read latency is exactly 1 cycle, with no waitrequest. avs_readdata holds its last value when no read is issued.
- Simultaneous read and write to one register: the read returns the pre-write value.
- RW1C write in the same cycle as a new edge on that bit: the set wins and the bit stays 1.
- Write to EDGE_SEL does not retro-capture: only future stable transitions are evaluated.
- pio_out_export is DATA_OUT, driven directly from flops. It updates the cycle after the write.
- Reset mid-debounce: the counter and stable state return to reset values and no edge is recorded.
- First post-reset mismatch between input and IN_RST_VAL: debounced and captured like any other change. Firmware clears EDGE_CAP after init.

Decomposition:
- Package hps_pio_pkg:
  - register index localparams: REG_DATA_IN .. REG_INFO.
  - bus data width constant: 32.
  - function for counter width.
- Sub-module pio_debounce: one bit wide, instantiated IN_W times by generate. It contains the synchroniser, counter, stable flop and a one-cycle rise/fall pulse pair.
- Top level holds the register file, edge capture and irq.

Test Plan:
- Reset with IN_RST_VAL=0, pio_in=0 -> DATA_IN=0, DATA_OUT=0, irq=0; read INFO -> 0x000A000A.
- DEBOUNCE_CYCLES=4: step pio_in[0] 0->1 -> DATA_IN[0]=1 exactly 6 cycles later; a 3-cycle pulse on bit 1 -> DATA_IN stays 0, EDGE_CAP stays 0.
- Write DATA_OUT=0x0F0, OUT_SET=0x003, OUT_CLR=0x030 -> pio_out_export = 0x0F3, then 0x0C3, each one cycle after its write; reads of idx2/3 return 0.
- IRQ_MASK=0x1, EDGE_SEL=0x0 (falling): drive bit0 1->0 -> EDGE_CAP=0x1 and irq=1 one cycle later; write EDGE_CAP=0x1 -> irq=0; a rising edge on bit0 sets nothing.
- Write-1-clear to EDGE_CAP bit2 in the same cycle as a new bit2 edge -> EDGE_CAP[2] remains 1.
- Assert reset_reset_n low asynchronously mid-debounce with DATA_OUT=0x3FF -> all outputs reach their reset values immediately without a clock edge; after release, no spurious EDGE_CAP if pio_in equals IN_RST_VAL.
